// File: rtl/clc_key.sv
// Diffie-Hellman shared-key engine: key = r_in^x mod p using MSB-first square-and-multiply
// over a bit-serial interleaved modular multiplier. Define CLC_KEY_CT_EN for constant-time MUL.
module clc_key #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] r_in,
  input  logic [W-1:0] x,
  input  logic [W-1:0] p,
  input  logic         st,
  output logic [W-1:0] key,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;

`ifdef CLC_KEY_CT_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, INIT, SQR, MUL, DONE} state_t;

  state_t        state;
  logic [W-1:0]  rl, xl, pl, res;
  logic [W+1:0]  acc;
  logic [IW-1:0] idx, mcnt;

  logic [W-1:0]  mul_a, addend;
  logic [W+1:0]  sum, d1, acc_nx;
  logic          last;

  // One shift-add step: 2*acc + a < 3p, so two conditional subtracts restore acc < p.
  always_comb begin
    mul_a  = (state == MUL) ? rl : res;
    addend = res[mcnt] ? mul_a : '0;
    sum    = {acc[W:0], 1'b0} + {2'b00, addend};
    d1     = (sum >= {2'b00, pl}) ? sum - {2'b00, pl} : sum;
    acc_nx = (d1 >= {2'b00, pl}) ? d1 - {2'b00, pl} : d1;
    last   = (mcnt == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rl    <= '0;
      xl    <= '0;
      pl    <= '0;
      res   <= '0;
      acc   <= '0;
      idx   <= '0;
      mcnt  <= '0;
      key   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (st) begin
            rl    <= r_in;
            xl    <= x;
            pl    <= p;
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= INIT;
          end
        end
        INIT: begin
          if (pl < W'(2) || rl >= pl) begin
            err   <= 1'b1;
            res   <= '0;
            state <= DONE;
          end else begin
            res   <= W'(1);
            idx   <= IW'(W - 1);
            mcnt  <= IW'(W - 1);
            acc   <= '0;
            state <= SQR;
          end
        end
        SQR: begin
          acc  <= acc_nx;
          mcnt <= mcnt - 1'b1;
          if (last) begin
            res  <= acc_nx[W-1:0];
            acc  <= '0;
            mcnt <= IW'(W - 1);
            if (CT || xl[idx])    state <= MUL;
            else if (idx == '0)   state <= DONE;
            else                  idx   <= idx - 1'b1;
          end
        end
        MUL: begin
          acc  <= acc_nx;
          mcnt <= mcnt - 1'b1;
          if (last) begin
            // In constant-time mode the product of a 0 bit is computed and discarded.
            if (xl[idx]) res <= acc_nx[W-1:0];
            acc  <= '0;
            mcnt <= IW'(W - 1);
            if (idx == '0) state <= DONE;
            else begin
              idx   <= idx - 1'b1;
              state <= SQR;
            end
          end
        end
        DONE: begin
          key   <= res;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/clc_key.md
CLC_KEY -- requirements
Module: clc_key

Interface
REQ-001 Parameter W, default 32, operand width of base, exponent, modulus and key in bits.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 r_in  input  W  public value received from the peer (peer's g^x mod p).
REQ-005 x  input  W  local private exponent.
REQ-006 p  input  W  prime modulus.
REQ-007 st  input  1  start request, sampled only in IDLE.
REQ-008 key  output  W  shared secret K = r_in^x mod p.
REQ-009 busy  output  1  high while a computation is in progress.
REQ-010 done  output  1  one-cycle pulse when key and err are valid.
REQ-011 err  output  1  invalid operands on the last accepted request.

Function
REQ-012 The block SHALL implement FSM states IDLE, INIT, SQR, MUL and DONE.
REQ-013 In IDLE with st=1, it SHALL latch r_in, x and p, clear err, and go to INIT; busy SHALL be high from the next cycle until DONE exits.
REQ-014 INIT SHALL flag err when p<2 or r_in>=p and go directly to DONE with key=0; otherwise it SHALL set result=1 and bit index=W-1 and go to SQR.
REQ-015 Exponent bits SHALL be scanned from MSB to LSB; per bit, SQR computes result*result mod p and MUL computes result*r_in mod p.
REQ-016 Each modular multiply SHALL be interleaved shift-add taking exactly W cycles: acc = 2*acc + (b[i] ? a : 0), then subtract p at most twice, with a W+2-bit accumulator and acc < p after each step.
REQ-017 The MUL product SHALL be committed to result only when the current exponent bit is 1; otherwise result keeps the SQR value.
REQ-018 After the MUL phase of bit 0, the FSM SHALL go to DONE, load key from result and pulse done for one cycle, then return to IDLE with busy=0.
REQ-019 With valid operands, latency from the st-sampling edge to the done cycle SHALL be 2 + 2*W*W cycles (2050 for W=32).
REQ-020 On an err request, done SHALL assert 2 cycles after the st-sampling edge.
REQ-021 st SHALL be ignored outside IDLE, and input changes while busy SHALL NOT affect the result.
REQ-022 key and err SHALL hold their values until the next accepted st.
REQ-023 x=0 SHALL yield key=1, and r_in=0 with x≠0 SHALL yield key=0.

Reset
REQ-024 While rst=1, the block SHALL force key=0, busy=0, done=0, err=0, FSM state IDLE, and clear all internal registers.
REQ-025 rst asserted mid-computation SHALL abort it with no done pulse; the first st after rst deasserts SHALL be accepted normally.

Configuration
REQ-026 With macro CLC_KEY_CT_EN defined, MUL SHALL run for every exponent bit (constant time, latency per REQ-019).
REQ-027 Without CLC_KEY_CT_EN, MUL SHALL be skipped for 0 bits, and latency SHALL be 2 + W*(W + popcount(x)) cycles.
REQ-028 The key value SHALL be identical in both builds.

Verification
REQ-029 r_in=6, x=3, p=17, st pulse -> key=12, err=0; done at cycle 2050 (CT build) or 1090 (non-CT build).
REQ-030 r_in=3, x=0, p=23 -> key=1, err=0.
REQ-031 r_in=0xFFFFFFFA, x=2, p=0xFFFFFFFB -> key=1 (accumulator overflow path exercised).
REQ-032 p=1 or r_in=20 with p=17 -> err=1, key=0, done 2 cycles after st.
REQ-033 st re-pulsed and r_in changed while busy -> no effect on the running job; its key is unchanged.
REQ-034 rst asserted mid-run -> all outputs 0 and no done pulse; a new request afterwards completes correctly.
